// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command sequencer: opcodes, ALU selector codes,
// FSM states and the queued command layout.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam logic [6:0] OUT_AND  = 7'b1000000;
  localparam logic [6:0] OUT_OR   = 7'b0100000;
  localparam logic [6:0] OUT_NOT  = 7'b0010000;
  localparam logic [6:0] OUT_XOR  = 7'b0001000;
  localparam logic [6:0] OUT_ADD  = 7'b0000100;
  localparam logic [6:0] OUT_SUB  = 7'b0000010;
  localparam logic [6:0] OUT_MUL  = 7'b0000001;
  localparam logic [6:0] OUT_NONE = 7'b0000000;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StResp  = 2'b11
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic       chain;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  function automatic logic [6:0] op_onehot(input logic [2:0] op);
    logic [6:0] sel;
    case (op)
      OP_AND:  sel = OUT_AND;
      OP_OR:   sel = OUT_OR;
      OP_NOT:  sel = OUT_NOT;
      OP_XOR:  sel = OUT_XOR;
      OP_ADD:  sel = OUT_ADD;
      OP_SUB:  sel = OUT_SUB;
      OP_MUL:  sel = OUT_MUL;
      default: sel = OUT_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue for the sequencer: DEPTH entries of cmd_t, pointers carry an
// extra wrap bit so full and empty are distinguishable.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  cmd_t        mem_q [DEPTH];
  cmd_t        mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers cover them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives the registered 8-bit ALU from a command queue, waits out its latency
// and returns one response per command; results also feed a chaining accumulator.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_chain,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [2:0] alu_in_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_ovf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_ovf,
  output logic       rsp_err,
  output logic       busy,
  output logic [1:0] state
);

  state_e     state_q, state_d;
  cmd_t       cur_q, cur_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_ovf_q, rsp_ovf_d;
  logic       rsp_err_q, rsp_err_d;

  cmd_t fifo_wdata, fifo_rdata;
  logic fifo_pop, fifo_full, fifo_empty;

  assign fifo_wdata = '{op: cmd_op, chain: cmd_chain, a: cmd_a, b: cmd_b};

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_rdata;
          state_d  = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        state_d = StResp;
        if (cur_q.op == OP_RSVD) begin
          rsp_data_d = 8'h00;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_result;
          rsp_ovf_d  = (cur_q.op == OP_MUL) && alu_ovf;
          rsp_err_d  = 1'b0;
          acc_d      = alu_result;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_rdata;
            state_d  = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ALU lines are only active during ISSUE; a reserved opcode never loads.
  always_comb begin
    alu_in_sel  = SEL_PERSIST;
    alu_num1    = 8'h00;
    alu_num2    = 8'h00;
    alu_out_sel = OUT_NONE;
    if (state_q == StIssue && cur_q.op != OP_RSVD) begin
      alu_in_sel  = SEL_LOAD;
      alu_num1    = cur_q.chain ? acc_q : cur_q.a;
      alu_num2    = cur_q.b;
      alu_out_sel = op_onehot(cur_q.op);
    end
  end

  assign cmd_ready = !fifo_full;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = !fifo_empty || (state_q != StIdle);
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      acc_q      <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-cycle-latency ALU model.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_chain;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1, alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_result;
  logic       alu_ovf;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_ovf, rsp_err, busy;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_chain  (cmd_chain),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_in_sel (alu_in_sel),
    .alu_num1   (alu_num1),
    .alu_num2   (alu_num2),
    .alu_out_sel(alu_out_sel),
    .alu_result (alu_result),
    .alu_ovf    (alu_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .state      (state)
  );

  // ALU model: registers the selected operation on a load, otherwise persists.
  logic [7:0]  m_res = 8'h00;
  logic        m_ovf = 1'b0;
  logic [15:0] m_prod;
  assign m_prod     = {8'h00, alu_num1} * {8'h00, alu_num2};
  assign alu_result = m_res;
  assign alu_ovf    = m_ovf;

  always @(posedge clk) begin
    if (alu_in_sel == 3'b010) begin
      m_ovf <= 1'b0;
      case (alu_out_sel)
        7'b1000000: m_res <= alu_num1 & alu_num2;
        7'b0100000: m_res <= alu_num1 | alu_num2;
        7'b0010000: m_res <= ~alu_num1;
        7'b0001000: m_res <= alu_num1 ^ alu_num2;
        7'b0000100: m_res <= alu_num1 + alu_num2;
        7'b0000010: m_res <= alu_num1 - alu_num2;
        7'b0000001: begin
          m_res <= m_prod[7:0];
          m_ovf <= |m_prod[15:8];
        end
        default: m_res <= 8'hEE;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic chain, input logic [7:0] a,
                          input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_chain = chain;
    cmd_a     = a;
    cmd_b     = b;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    check_eq("push_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(input string tag, input logic [7:0] d, input logic o, input logic e);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    check_eq({tag, "_valid"}, rsp_valid, 1);
    check_eq({tag, "_data"}, rsp_data, d);
    check_eq({tag, "_ovf"}, rsp_ovf, o);
    check_eq({tag, "_err"}, rsp_err, e);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fill_exp [5];
    int         got_n, last_c;
    logic       saw_flag;

    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 3'd0; cmd_chain = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00;
    tick(); tick();
    rst = 1'b1;

    // Reset state
    check_eq("rst_state", state, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_rsp_flags", {rsp_ovf, rsp_err}, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_sel", alu_in_sel, 3'b100);
    check_eq("rst_alu_lines", {alu_num1, alu_num2, alu_out_sel}, 0);

    // ADD with cycle-exact latency
    push_cmd(3'd4, 1'b0, 8'h0F, 8'h01);
    check_eq("add_k1_state", state, 0);
    tick();
    check_eq("add_issue_state", state, 1);
    check_eq("add_issue_sel", alu_in_sel, 3'b010);
    check_eq("add_issue_nums", {alu_num1, alu_num2}, 16'h0F01);
    check_eq("add_issue_out", alu_out_sel, 7'b0000100);
    tick();
    check_eq("add_wait_state", state, 2);
    check_eq("add_wait_sel", alu_in_sel, 3'b100);
    check_eq("add_wait_valid", rsp_valid, 0);
    tick();
    check_eq("add_k4_valid", rsp_valid, 1);
    take_rsp("add", 8'h10, 1'b0, 1'b0);
    check_eq("add_idle", state, 0);

    // MUL overflow
    push_cmd(3'd6, 1'b0, 8'h20, 8'h10);
    tick();
    check_eq("mul_issue_out", alu_out_sel, 7'b0000001);
    take_rsp("mul", 8'h00, 1'b1, 1'b0);

    // Chained SUB uses accumulator
    push_cmd(3'd4, 1'b0, 8'h05, 8'h03);
    take_rsp("add2", 8'h08, 1'b0, 1'b0);
    push_cmd(3'd5, 1'b1, 8'hAA, 8'h02);
    tick();
    check_eq("chain_issue_nums", {alu_num1, alu_num2}, 16'h0802);
    take_rsp("chain_sub", 8'h06, 1'b0, 1'b0);

    // Fill: one in flight plus four queued while rsp_ready is low
    fill_exp = '{8'h02, 8'h33, 8'hF0, 8'h30, 8'hAA};
    push_cmd(3'd4, 1'b0, 8'h01, 8'h01);
    push_cmd(3'd1, 1'b0, 8'h30, 8'h03);
    push_cmd(3'd3, 1'b0, 8'hFF, 8'h0F);
    push_cmd(3'd0, 1'b0, 8'hF0, 8'h3C);
    push_cmd(3'd2, 1'b0, 8'h55, 8'h00);
    check_eq("fill_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'h77; cmd_b = 8'h77;
    tick(); tick(); tick();
    check_eq("fill_stall_ready", cmd_ready, 0);
    check_eq("fill_hold_state", state, 3);
    check_eq("fill_hold_data", rsp_data, 8'h02);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    got_n = 0;
    last_c = 0;
    for (int c = 0; c < 40 && got_n < 5; c++) begin
      if (rsp_valid) begin
        check_eq($sformatf("fill_data%0d", got_n), rsp_data, fill_exp[got_n]);
        if (got_n > 0) check_eq("fill_cadence", c - last_c, 3);
        last_c = c;
        got_n++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    check_eq("fill_count", got_n, 5);
    check_eq("fill_idle", state, 0);

    // Reserved opcode: no load, error response, accumulator untouched
    push_cmd(3'd7, 1'b0, 8'h11, 8'h22);
    saw_flag = 1'b0;
    for (int i = 0; i < 10 && !rsp_valid; i++) begin
      if (alu_in_sel == 3'b010) saw_flag = 1'b1;
      if (state == 2'd1) check_eq("rsvd_out_sel", alu_out_sel, 0);
      tick();
    end
    check_eq("rsvd_no_load", saw_flag, 0);
    take_rsp("rsvd", 8'h00, 1'b0, 1'b1);
    push_cmd(3'd1, 1'b1, 8'h00, 8'h00);
    take_rsp("after_rsvd_or", 8'hAA, 1'b0, 1'b0);

    // Reset during WAIT with two commands queued
    push_cmd(3'd4, 1'b0, 8'h01, 8'h02);
    push_cmd(3'd4, 1'b0, 8'h03, 8'h04);
    push_cmd(3'd4, 1'b0, 8'h05, 8'h06);
    check_eq("mid_rst_wait", state, 2);
    rst = 1'b0;
    tick();
    check_eq("mid_rst_state", state, 0);
    check_eq("mid_rst_valid", rsp_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", cmd_ready, 1);
    rst = 1'b1;
    rsp_ready = 1'b1;
    saw_flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid || busy) saw_flag = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    check_eq("mid_rst_no_rsp", saw_flag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
